// File: rtl/inv_key_expand.sv
// AES-128 inverse key schedule: streams round keys 10 down to 0 over a valid/ready port.
// Define INV_KEY_FWD_PASS_EN to load the cipher key and derive the round-10 key internally.
module inv_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

`ifdef INV_KEY_FWD_PASS_EN
  typedef enum logic [1:0] {StIdle, StFwd, StEmit} state_e;
`else
  typedef enum logic [1:0] {StIdle, StEmit} state_e;
`endif

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SboxTbl[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  state_e       state;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic         valid_q;

  logic [31:0]  a0, a1, a2, a3;
  logic [31:0]  w3_prev;
  logic [31:0]  sub_in, sub_out;
  logic [3:0]   rcon_idx;
  logic [31:0]  head;
  logic [127:0] prev_key;

  assign {a0, a1, a2, a3} = key_q;
  assign w3_prev = a3 ^ a2;

`ifdef INV_KEY_FWD_PASS_EN
  logic         fwd_sel;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  // The single S-box word serves both directions; the state picks its input word and rcon.
  assign fwd_sel  = (state == StFwd);
  assign sub_in   = fwd_sel ? {a3[23:0], a3[31:24]} : {w3_prev[23:0], w3_prev[31:24]};
  assign rcon_idx = fwd_sel ? round_q + 4'd1 : round_q;
  assign n0       = head;
  assign n1       = n0 ^ a1;
  assign n2       = n1 ^ a2;
  assign n3       = n2 ^ a3;
  assign next_key = {n0, n1, n2, n3};
`else
  assign sub_in   = {w3_prev[23:0], w3_prev[31:24]};
  assign rcon_idx = round_q;
`endif

  assign sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                     sbox(sub_in[15:8]), sbox(sub_in[7:0])};
  assign head     = a0 ^ sub_out ^ {rcon(rcon_idx), 24'h0};
  assign prev_key = {head, a1 ^ a0, a2 ^ a1, w3_prev};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= StIdle;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (key_valid) begin
            key_q <= key_in;
`ifdef INV_KEY_FWD_PASS_EN
            state   <= StFwd;
            round_q <= 4'd0;
`else
            state   <= StEmit;
            round_q <= 4'd10;
            valid_q <= 1'b1;
`endif
          end
        end
`ifdef INV_KEY_FWD_PASS_EN
        StFwd: begin
          key_q   <= next_key;
          round_q <= round_q + 4'd1;
          if (round_q == 4'd9) begin
            state   <= StEmit;
            valid_q <= 1'b1;
          end
        end
`endif
        StEmit: begin
          if (rk_ready) begin
            if (round_q == 4'd0) begin
              state   <= StIdle;
              valid_q <= 1'b0;
            end else begin
              key_q   <= prev_key;
              round_q <= round_q - 4'd1;
            end
          end
        end
        default: begin
          state   <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gated by rst_n so no key is offered while a reset is being sampled.
  assign key_ready = rst_n && (state == StIdle);
  assign busy      = (state != StIdle);
  assign rk_out    = key_q;
  assign rk_round  = round_q;
  assign rk_valid  = valid_q;

endmodule

// File: tb/tb_inv_key_expand.sv
// Directed bench for inv_key_expand: FIPS-197 schedule, backpressure, ignored loads,
// mid-sequence reset and an all-zero round-10 key checked against a GF(2^8) model.
module tb_inv_key_expand;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic         busy;

  always #5 clk = ~clk;

  inv_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

`ifdef INV_KEY_FWD_PASS_EN
  localparam int LoadLat = 10;
`else
  localparam int LoadLat = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] exp_rk  [0:10];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: inverse in GF(2^8) followed by the affine map.
  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] r;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    s = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [7:0] m_rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 1; i < r; i++) c = gmul(c, 8'h02);
    return c;
  endfunction

  function automatic logic [127:0] m_back(input logic [127:0] k, input int r);
    logic [31:0] a0, a1, a2, a3, w3, t;
    {a0, a1, a2, a3} = k;
    w3 = a3 ^ a2;
    t  = {w3[23:0], w3[31:24]};
    t  = {m_sbox(t[31:24]), m_sbox(t[23:16]), m_sbox(t[15:8]), m_sbox(t[7:0])};
    return {a0 ^ t ^ {m_rcon(r), 24'h0}, a1 ^ a0, a2 ^ a1, w3};
  endfunction

  task automatic load_key(input string tag);
    int w;
    int lat;
    w = 0;
    lat = 0;
    while (!key_ready && w < 50) begin
      w++;
      tick();
    end
    check_eq($sformatf("%s key_ready before load", tag), 128'(key_ready), 128'(1));
`ifdef INV_KEY_FWD_PASS_EN
    key_in = exp_rk[0];
`else
    key_in = exp_rk[10];
`endif
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    while (!rk_valid && lat < 40) begin
      lat++;
      tick();
    end
    check_eq($sformatf("%s load latency", tag), 128'(lat), 128'(LoadLat));
  endtask

  task automatic collect(input string tag, input bit rand_ready, input bit inject);
    int beats;
    int cyc;
    bit stalled;
    logic [127:0] hold_k;
    logic [3:0]   hold_r;
    beats = 0;
    cyc = 0;
    stalled = 1'b0;
    hold_k = '0;
    hold_r = '0;
    while (beats < 11 && cyc < 300) begin
      key_valid = 1'b0;
      if (stalled) begin
        check_eq($sformatf("%s hold key", tag), rk_out, hold_k);
        check_eq($sformatf("%s hold round", tag), 128'(rk_round), 128'(hold_r));
      end
      if (inject && cyc == 3) begin
        check_eq($sformatf("%s key_ready while busy", tag), 128'(key_ready), 128'(0));
        key_valid = 1'b1;
        key_in    = 128'h00112233445566778899aabbccddeeff;
      end
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled  = rk_valid && !rk_ready;
      hold_k   = rk_out;
      hold_r   = rk_round;
      if (rk_valid && rk_ready) begin
        check_eq($sformatf("%s beat %0d round", tag, beats), 128'(rk_round), 128'(10 - beats));
        check_eq($sformatf("%s beat %0d key", tag, beats), rk_out, exp_rk[10 - beats]);
        beats++;
      end
      cyc++;
      tick();
    end
    key_valid = 1'b0;
    check_eq($sformatf("%s beat count", tag), 128'(beats), 128'(11));
    if (!rand_ready) check_eq($sformatf("%s cycles", tag), 128'(cyc), 128'(11));
    check_eq($sformatf("%s key_ready after", tag), 128'(key_ready), 128'(1));
    check_eq($sformatf("%s busy after", tag), 128'(busy), 128'(0));
    check_eq($sformatf("%s rk_valid after", tag), 128'(rk_valid), 128'(0));
  endtask

  initial begin
    int n;
    fips_rk = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    exp_rk = fips_rk;

    tick();
    tick();
    check_eq("reset rk_valid", 128'(rk_valid), 128'(0));
    check_eq("reset rk_out", rk_out, 128'(0));
    check_eq("reset rk_round", 128'(rk_round), 128'(0));
    check_eq("reset busy", 128'(busy), 128'(0));
    check_eq("reset key_ready", 128'(key_ready), 128'(0));
    rst_n = 1'b1;
    tick();
    check_eq("key_ready after release", 128'(key_ready), 128'(1));

    load_key("fips");
    collect("fips", 1'b0, 1'b0);

    load_key("bp");
    collect("bp", 1'b1, 1'b0);

    load_key("busy");
    collect("busy", 1'b0, 1'b1);

    load_key("rst");
    rk_ready = 1'b1;
    n = 0;
    while (!(rk_valid && rk_round == 4'd5) && n < 40) begin
      n++;
      tick();
    end
    check_eq("rst reached beat 5", 128'(rk_round), 128'(5));
    rst_n = 1'b0;
    #1;
    check_eq("rst key_ready low", 128'(key_ready), 128'(0));
    tick();
    check_eq("rst rk_valid", 128'(rk_valid), 128'(0));
    check_eq("rst busy", 128'(busy), 128'(0));
    check_eq("rst rk_out", rk_out, 128'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("rst idle %0d rk_valid", i), 128'(rk_valid), 128'(0));
    end
    load_key("reload");
    collect("reload", 1'b0, 1'b0);

    exp_rk[10] = '0;
    for (int r = 10; r >= 1; r--) exp_rk[r - 1] = m_back(exp_rk[r], r);
    load_key("zero");
    collect("zero", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/inv_key_expand.md
# inv_key_expand

Sequential AES-128 inverse key schedule. Given the final (round-10) round key, it regenerates the round keys in decryption order, 10 down to 0, one key per output beat. The combinational forward round-key stage serves encryption; this block is its decryption-side counterpart and feeds the inverse cipher round engine over a valid/ready stream.

## Interface

Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- key_in  input  128  load key: the round-10 key, or the cipher key when INV_KEY_FWD_PASS_EN is defined. word0 = [127:96].
- key_valid  input  1  key_in is valid.
- key_ready  output  1  block can accept a key; high only in IDLE.
- rk_out  output  128  current round key, same word order as key_in.
- rk_round  output  4  round index of rk_out, 10 down to 0.
- rk_valid  output  1  rk_out and rk_round are valid.
- rk_ready  input  1  consumer accepts the current round key.
- busy  output  1  high in any state other than IDLE.

## Operation

- States: IDLE, FWD (only with the macro), EMIT.
- IDLE: key_ready=1. When key_valid=1 the key is captured into a 128-bit register. Without the macro the state goes to EMIT with round=10. With the macro the state goes to FWD with round=0.
- FWD: each cycle applies one forward round step with rcon(round+1) and increments round. When round reaches 10 the state goes to EMIT. rk_valid=0 throughout FWD.
- EMIT: rk_valid=1, rk_out=key register, rk_round=round.
  - Outputs hold stable while rk_ready=0.
  - On rk_valid&&rk_ready with round>0: the register loads the previous key and round decrements.
  - On rk_valid&&rk_ready with round==0: the state returns to IDLE.
- Backward step, from key (a0,a1,a2,a3) at round r:
  - w3 = a3^a2, w2 = a2^a1, w1 = a1^a0.
  - w0 = a0 ^ SubWord(RotWord(w3)) ^ {rcon(r),24'h0}.
  - RotWord moves byte [31:24] to the LSB position. SubWord is the AES forward S-box on each byte.
- Forward step: the standard expansion, a0 = w0^SubWord(RotWord(w3))^{rcon,24'h0}, a1 = a0^w1, a2 = a1^w2, a3 = a2^w3.
- rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36. The backward step uses rcon(r) for r=10..1. All arithmetic is XOR; no carries.
- One S-box word (4 instances) is shared by the FWD and EMIT datapaths and muxed on state.
- key_valid in any state other than IDLE is ignored (key_ready=0). No key is queued.
- rk_ready while rk_valid=0 is ignored.

## Timing

- Reset (rst_n low at a rising edge):
  - state becomes IDLE; key register and round are zeroed.
  - rk_valid=0, rk_out=0, rk_round=0, busy=0.
  - key_ready=0 during any cycle in which rst_n is sampled low; 1 from the first cycle after release.
- Reset mid-operation aborts the sequence immediately. No further rk_valid beats occur until a new key is loaded.
- Load latency, key handshake at edge N:
  - Without the macro: rk_valid=1 with round 10 in the cycle after edge N.
  - With the macro: 10 FWD cycles, then rk_valid=1 in the cycle after edge N+10.
- Throughput: with rk_ready held high, one key per cycle. 11 consecutive beats, rounds 10..0.
- After the round-0 handshake, key_ready=1 in the next cycle. A new key can therefore be accepted at the earliest 1 cycle after the last beat.
- rk_out, rk_round and rk_valid are registered outputs.

## Configuration

- INV_KEY_FWD_PASS_EN defined: key_in is the cipher key (round 0). The FWD state and the forward datapath are compiled in, and the block derives the round-10 key itself before emitting.
- INV_KEY_FWD_PASS_EN undefined: key_in must be the round-10 key. The FWD state and the forward XOR chain are compiled out.
- The emitted sequence is identical in both builds.

## Test plan

- No macro, with rk_ready=1, load d014f9a8c9ee2589e13f0cc8b6630ca6:
  - beat 0: rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - beat 1: rk_round=9, rk_out=ac7766f319fadc2128d12941575c006e.
  - beat 9: rk_round=1, rk_out=a0fafe1788542cb123a339392a6c7605.
  - beat 10: rk_round=0, rk_out=2b7e151628aed2a6abf7158809cf4f3c.
  - The 11 beats occur in consecutive cycles, then key_ready=1.
- Macro, load 2b7e151628aed2a6abf7158809cf4f3c:
  - rk_valid stays 0 for 10 cycles.
  - The first beat is round 10, d014f9a8c9ee2589e13f0cc8b6630ca6.
  - The remaining beats match the previous scenario.
- Backpressure, random rk_ready: rk_out and rk_round hold while rk_ready=0. No key is skipped or repeated; 11 accepted beats total.
- key_valid pulsed while busy=1 with a different key: the pulse is ignored and the current sequence completes unchanged.
- rst_n low at beat 5 for one cycle:
  - the next cycle shows rk_valid=0, busy=0, rk_out=0.
  - a reload then restarts the sequence at round 10.
- All-zero round-10 key: the beats match a software inverse-schedule model for every round.
